opb_snapshot_bank_simulink2ppc: RTL

Multi-channel, software-readable capture bank on the OPB slave bus, the parametrised successor of the single-word simulink2ppc register. It latches C_NUM_CH 32-bit fabric words simultaneously into a coherent snapshot. The snapshot is triggered by a software write, a fabric strobe, or optionally a read of channel 0. This lets the PPC read multi-word quantities, such as split MCNT MSB/LSB pairs, without tearing. It sits between the design's Simulink-generated logic and the OPB, in the OPB clock domain.

---
 rtl/opb_snapshot_bank_simulink2ppc.sv | 76 +++++++
 1 files changed

// File: rtl/opb_snapshot_bank_simulink2ppc.sv
// opb_snapshot_bank_simulink2ppc: OPB slave that latches C_NUM_CH fabric words into one coherent snapshot.
// Capture sources are a CTRL write, the user_snap strobe, or (when auto_en is set) a read of channel 0.
module opb_snapshot_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR     = 32'h01010000,
    parameter logic [31:0] C_HIGHADDR     = 32'h010100FF,
    parameter int          C_OPB_AWIDTH   = 32,
    parameter int          C_OPB_DWIDTH   = 32,
    parameter              C_FAMILY       = "virtex5",
    parameter int          C_NUM_CH       = 4,
    parameter bit          C_AUTO_DEFAULT = 1'b0
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [32*C_NUM_CH-1:0]  user_data_in,
    input  logic                    user_snap
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_nx;
    logic [31:0] addr, off, dbus, rdata;
    logic [29:0] idx;
    logic hit, go, ctrl_wr, auto_rd, cap, auto_en;
    logic [15:0] snap_count;
    logic [31:0] ch [C_NUM_CH];
    logic unused_ok;
    // Bus bit 0 is the MSB, so a straight assignment maps register bit n to bus bit 31-n.
    assign addr = OPB_ABus;
    assign dbus = OPB_DBus;
    assign off = addr - C_BASEADDR;
    assign idx = off[31:2];
    assign hit = OPB_select && addr >= C_BASEADDR && addr <= C_HIGHADDR;
    assign Sl_xferAck = state == ACK;
    assign Sl_errAck = 1'b0;
    assign Sl_retry = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign unused_ok = &{1'b0, OPB_seqAddr, dbus[31:2], OPB_BE[0:2], off[1:0], |C_FAMILY};
    always_comb begin
        state_nx = (hit && !Sl_xferAck) ? ACK : IDLE;
        go = state_nx == ACK;
        ctrl_wr = go && !OPB_RNW && idx == 30'd0 && OPB_BE[3];
        auto_rd = go && OPB_RNW && idx == 30'd1 && auto_en;
        cap = (ctrl_wr && dbus[0]) || user_snap || auto_rd;
    end
    // A read coinciding with a capture returns the freshly captured word so auto reads stay coherent.
    always_comb begin
        rdata = (idx == 30'd0) ? {snap_count, 14'd0, auto_en, 1'b0} : 32'd0;
        for (int k = 0; k < C_NUM_CH; k++)
            if (idx == 30'(k + 1)) rdata = cap ? user_data_in[32*k +: 32] : ch[k];
    end
    always_ff @(posedge OPB_Clk or posedge OPB_Rst)
        state <= OPB_Rst ? IDLE : state_nx;
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            Sl_DBus <= '0;
            snap_count <= '0;
            auto_en <= C_AUTO_DEFAULT;
            for (int k = 0; k < C_NUM_CH; k++) ch[k] <= '0;
        end else begin
            Sl_DBus <= (go && OPB_RNW) ? rdata : 32'd0;
            snap_count <= cap ? snap_count + 16'd1 : snap_count;
            auto_en <= ctrl_wr ? dbus[1] : auto_en;
            for (int k = 0; k < C_NUM_CH; k++)
                if (cap) ch[k] <= user_data_in[32*k +: 32];
        end
    end
endmodule
